// File: rtl/pulse_pkg.sv
// Shared definitions for the multi-channel pulse generator.
// Optional feature macro: PULSE_DELAY_EN (enables the trigger-to-pulse DELAY state).
package pulse_pkg;

  // Per-channel FSM states; encoding is stable whether or not DELAY is built in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_DONE  = 2'd3
  } pulse_state_e;

  localparam int DEF_CNT_W = 36;
  localparam int DEF_N_CH  = 4;

endpackage

// File: rtl/pulse_ch.sv
// One independent pulse channel: trigger select, optional delay, timed pulse,
// then an end-of-pulse launch flag held until the trigger is released.
// Optional feature macro: PULSE_DELAY_EN (without it, the delay input is ignored).
module pulse_ch
  import pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_Pulse,
  input  logic             rst,
  input  logic             CHTS,
  input  logic             PL_start,
  input  logic             PL_launch,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] duration,
  output logic             PL_out,
  output logic             launch_DL,
  output logic             busy,
  output pulse_state_e     state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Selected trigger level; re-evaluated every edge so a CHTS change mid-run
  // simply swaps which level the FSM watches.
  logic trg;
  assign trg = CHTS ? PL_start : PL_launch;

  // Remaining cycles in the current timed state (DELAY or PULSE) minus one.
  // Counting down and stopping at zero means it can never wrap.
  logic [CNT_W-1:0] cnt;

`ifdef PULSE_DELAY_EN
  // Duration captured at trigger time, consumed when DELAY expires.
  logic [CNT_W-1:0] dur_q;
`else
  logic unused_delay;
  assign unused_delay = ^delay;
`endif

  // Channel FSM with registered outputs; any trg=0 in DELAY/PULSE aborts to IDLE.
  always_ff @(posedge clk_Pulse) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
`ifdef PULSE_DELAY_EN
      dur_q     <= '0;
`endif
      PL_out    <= 1'b0;
      launch_DL <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trg) begin
`ifdef PULSE_DELAY_EN
            dur_q <= duration;
            if (delay != '0) begin
              state <= ST_DELAY;
              cnt   <= delay - CNT_ONE;
              busy  <= 1'b1;
            end else if (duration != '0) begin
              state  <= ST_PULSE;
              cnt    <= duration - CNT_ONE;
              PL_out <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state     <= ST_DONE;
              launch_DL <= 1'b1;
            end
`else
            if (duration != '0) begin
              state  <= ST_PULSE;
              cnt    <= duration - CNT_ONE;
              PL_out <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state     <= ST_DONE;
              launch_DL <= 1'b1;
            end
`endif
          end
        end
`ifdef PULSE_DELAY_EN
        ST_DELAY: begin
          if (!trg) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            if (dur_q != '0) begin
              state  <= ST_PULSE;
              cnt    <= dur_q - CNT_ONE;
              PL_out <= 1'b1;
            end else begin
              state     <= ST_DONE;
              launch_DL <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
`endif
        ST_PULSE: begin
          if (!trg) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            PL_out <= 1'b0;
            busy   <= 1'b0;
          end else if (cnt == '0) begin
            state     <= ST_DONE;
            PL_out    <= 1'b0;
            launch_DL <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (!trg) begin
            state     <= ST_IDLE;
            launch_DL <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          PL_out    <= 1'b0;
          launch_DL <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_multi_ch.sv
// N_CH independent pulse channels; this level only slices the packed buses.
// Optional feature macro: PULSE_DELAY_EN (per-channel trigger-to-pulse delay).
module pulse_multi_ch
  import pulse_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk_Pulse,
  input  logic                  rst,
  input  logic [N_CH-1:0]       CHTS,
  input  logic [N_CH-1:0]       PL_start,
  input  logic [N_CH-1:0]       PL_launch,
  input  logic [N_CH*CNT_W-1:0] delay,
  input  logic [N_CH*CNT_W-1:0] duration,
  output logic [N_CH-1:0]       PL_out,
  output logic [N_CH-1:0]       launch_DL,
  output logic [N_CH-1:0]       busy
);

  // Per-channel FSM state, kept as named nets for hierarchical probes.
  pulse_state_e unused_dbg_state [N_CH];

  // One channel instance per bit lane; channels share nothing but the clock and reset.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_Pulse (clk_Pulse),
      .rst       (rst),
      .CHTS      (CHTS[i]),
      .PL_start  (PL_start[i]),
      .PL_launch (PL_launch[i]),
      .delay     (delay[i*CNT_W +: CNT_W]),
      .duration  (duration[i*CNT_W +: CNT_W]),
      .PL_out    (PL_out[i]),
      .launch_DL (launch_DL[i]),
      .busy      (busy[i]),
      .state     (unused_dbg_state[i])
    );
  end

endmodule

// File: doc/pulse_multi_ch.md
PULSE_MULTI_CH -- requirements
Module: pulse_multi_ch

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of independent pulse channels (range 1..16).
REQ-002 SHALL have parameter CNT_W, default 36, meaning the width of the delay, duration and internal counters.
REQ-003 SHALL have port clk_Pulse  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port CHTS  input  N_CH  per-channel trigger select: 1 selects PL_start[i], 0 selects PL_launch[i].
REQ-006 SHALL have port PL_start  input  N_CH  per-channel internal trigger, level-sensitive.
REQ-007 SHALL have port PL_launch  input  N_CH  per-channel external/chained trigger, level-sensitive.
REQ-008 SHALL have port delay  input  N_CH*CNT_W  per-channel trigger-to-pulse delay in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port duration  input  N_CH*CNT_W  per-channel pulse width in cycles; same packing as delay.
REQ-010 SHALL have port PL_out  output  N_CH  per-channel pulse output, registered.
REQ-011 SHALL have port launch_DL  output  N_CH  per-channel end-of-pulse flag that launches the downstream delay line, registered.
REQ-012 SHALL have port busy  output  N_CH  per-channel flag, high while in DELAY or PULSE.

Function
REQ-013 SHALL define trg[i] = CHTS[i] ? PL_start[i] : PL_launch[i], sampled at every rising edge.
REQ-014 SHALL implement one FSM per channel with states IDLE, DELAY, PULSE and DONE.
REQ-015 SHALL, in IDLE with trg=1, latch delay[i] and duration[i] into the channel; later changes on those inputs SHALL NOT affect the running pulse.
REQ-016 SHALL move from IDLE to DELAY when the latched delay is greater than 0, and directly to PULSE when it is 0.
REQ-017 SHALL stay in DELAY for exactly the latched delay cycles, then move to PULSE.
REQ-018 SHALL hold PL_out=1 for exactly the latched duration cycles; with delay=0, PL_out first rises on the edge that samples trg=1.
REQ-019 SHALL, with duration=0, produce no PL_out pulse and go straight to DONE.
REQ-020 SHALL assert launch_DL in DONE on the same edge that PL_out falls, and hold it while trg=1.
REQ-021 SHALL move from DONE to IDLE, clearing launch_DL, on the first edge that samples trg=0; re-arming SHALL require trg to go low and then high again.
REQ-022 SHALL abort from DELAY or PULSE to IDLE when trg=0 is sampled in either state, with PL_out=0 and launch_DL=0 on that edge.
REQ-023 SHALL NOT re-evaluate a running channel when CHTS[i] changes mid-operation; only the newly selected trg level applies (abort rules unchanged).
REQ-024 SHALL use counters of CNT_W bits that saturate, never wrap; the all-ones value SHALL be a valid delay and duration.
REQ-025 SHALL keep channels fully independent, with no shared counters or arbitration.

Reset
REQ-026 SHALL, with rst=1 at an edge, put all channels in IDLE, clear the counters, and drive PL_out=0, launch_DL=0 and busy=0 on that edge.
REQ-027 SHALL give rst priority over every trigger; a trigger held high through reset release SHALL be accepted on the first edge after rst falls.

Configuration
REQ-028 SHALL, with PULSE_DELAY_EN defined, implement the DELAY state as specified.
REQ-029 SHALL, without PULSE_DELAY_EN, keep the delay port but ignore it, omit the DELAY state and counter logic, and behave as if delay=0 on every channel.

Structure
REQ-030 SHALL put the FSM state enum, default CNT_W and default N_CH in shared package pulse_pkg.
REQ-031 SHALL implement one channel in sub-module pulse_ch and instantiate it N_CH times in a generate loop; the top SHALL only unpack the buses.

Verification
REQ-032 SHALL cover: ch0 CHTS=1, delay=0, duration=5, PL_start held high -> PL_out high 5 cycles from the trigger edge, then launch_DL=1 until PL_start falls.
REQ-033 SHALL cover: ch1 CHTS=0, delay=3, duration=2, PL_launch high -> busy at once, PL_out high in cycles 4-5, launch_DL from cycle 6.
REQ-034 SHALL cover: ch2 duration=10, trigger dropped at pulse cycle 4 -> PL_out and launch_DL low on the next edge, and a re-trigger starts a fresh 10-cycle pulse.
REQ-035 SHALL cover: ch3 duration=0 -> PL_out stays 0 and launch_DL=1 on the first edge after the trigger.
REQ-036 SHALL cover: rst pulsed during ch0 PULSE with ch1 in DELAY -> all outputs 0 on the reset edge, and both channels restart normally after release.
REQ-037 SHALL cover: build without PULSE_DELAY_EN, delay=7 -> PL_out rises on the trigger edge.
